// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: data-hazard and MDU-busy stall decision,
// F/D and PC enables, D/E bubble insert, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_D,
  input  logic [4:0]  dst_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  dst_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  output logic        en_F,
  output logic        en_D,
  output logic        flush_E,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md, stall;
  logic             busy_raw;

  // A source register of $zero never waits: the nonzero test also filters dst = 0.
  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               (((rs_D == dst_E) && (tuse_rs_D < tnew_E)) ||
                ((rs_D == dst_M) && (tuse_rs_D < tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               (((rt_D == dst_E) && (tuse_rt_D < tnew_E)) ||
                ((rt_D == dst_M) && (tuse_rt_D < tnew_M)));
  end

  // Outputs are forced to the free-running state while reset is held low.
  always_comb begin
    busy_raw = md_start_E || (busy_cnt_q != '0);
    md_busy  = reset && busy_raw;
    stall_md = md_D && md_busy;
    stall    = reset && (stall_rs || stall_rt || stall_md);
    en_F     = ~stall;
    en_D     = ~stall;
    flush_E  = stall;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (md_start_E) begin
      busy_cnt_d = md_div_E ? DIV_LD : MULT_LD;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle comparison against a
// cycle-indexed behavioural model plus hand-computed directed expectations.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, dst_E, dst_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_D, md_start_E, md_div_E;
  logic        en_F, en_D, flush_E, md_busy;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_D(md_D), .dst_E(dst_E), .tnew_E(tnew_E), .dst_M(dst_M), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E),
    .en_F(en_F), .en_D(en_D), .flush_E(flush_E), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the MDU is busy while the cycle index is below the end of its
  // latency window; the stall counter is a plain saturating integer.
  longint cyc = 0;
  longint busy_end = 0;
  longint unsigned mcnt = 0;

  function automatic bit haz(input int src, input int tuse, input int de, input int te,
                             input int dm, input int tm);
    if (src == 0) return 1'b0;
    return (src == de && tuse < te) || (src == dm && tuse < tm);
  endfunction

  function automatic bit exp_busy();
    return md_start_E || (cyc < busy_end);
  endfunction

  function automatic bit exp_stall();
    return haz(int'(rs_D), int'(tuse_rs_D), int'(dst_E), int'(tnew_E), int'(dst_M), int'(tnew_M)) ||
           haz(int'(rt_D), int'(tuse_rt_D), int'(dst_E), int'(tnew_E), int'(dst_M), int'(tnew_M)) ||
           (md_D && exp_busy());
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_end = 0;
      mcnt = 0;
    end else begin
      if (exp_stall() && mcnt != 64'hFFFF_FFFF) mcnt++;
      cyc++;
      if (md_start_E) busy_end = cyc + (md_div_E ? 10 : 5);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_en_F", {31'd0, en_F}, 32'd1);
      chk("rst_en_D", {31'd0, en_D}, 32'd1);
      chk("rst_flush_E", {31'd0, flush_E}, 32'd0);
      chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
    end else begin
      chk("cyc_en_F", {31'd0, en_F}, {31'd0, ~exp_stall()});
      chk("cyc_en_D", {31'd0, en_D}, {31'd0, ~exp_stall()});
      chk("cyc_flush_E", {31'd0, flush_E}, {31'd0, exp_stall()});
      chk("cyc_md_busy", {31'd0, md_busy}, {31'd0, exp_busy()});
      chk("cyc_stall_cnt", stall_cnt, mcnt[31:0]);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_D = 1'b0; dst_E = 5'd0; tnew_E = 2'd0; dst_M = 5'd0; tnew_M = 2'd0;
    md_start_E = 1'b0; md_div_E = 1'b0;
  endtask

  // Start an MDU op, hold mflo in D from the next cycle, count busy/stall cycles.
  task automatic run_md(input logic div, input int exp_b, input int exp_s, input string name);
    int nb, ns;
    nb = 0; ns = 0;
    md_start_E = 1'b1; md_div_E = div;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (md_busy) nb++;
      if (!en_D) ns++;
      next_cyc();
      if (i == 0) begin
        md_start_E = 1'b0; md_div_E = 1'b0; md_D = 1'b1;
      end
    end
    md_D = 1'b0;
    chk({name, "_busy_cycles"}, nb, exp_b);
    chk({name, "_stall_cycles"}, ns, exp_s);
  endtask

  initial begin
    reset = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("after_reset_cnt", stall_cnt, 32'd0);

    // no hazard
    next_cyc();
    rs_D = 5'd8; tuse_rs_D = 2'd0; dst_E = 5'd9; tnew_E = 2'd2; dst_M = 5'd10; tnew_M = 2'd1;
    repeat (3) next_cyc();
    @(negedge clk);
    chk("nohaz_en_D", {31'd0, en_D}, 32'd1);
    chk("nohaz_cnt", stall_cnt, 32'd0);

    // load-use: two stall cycles as the producer moves E -> M
    next_cyc();
    rs_D = 5'd8; tuse_rs_D = 2'd0; dst_E = 5'd8; tnew_E = 2'd2; dst_M = 5'd0; tnew_M = 2'd0;
    @(negedge clk);
    chk("lu1_en_D", {31'd0, en_D}, 32'd0);
    chk("lu1_flush_E", {31'd0, flush_E}, 32'd1);
    next_cyc();
    dst_E = 5'd0; tnew_E = 2'd0; dst_M = 5'd8; tnew_M = 2'd1;
    @(negedge clk);
    chk("lu2_en_F", {31'd0, en_F}, 32'd0);
    next_cyc();
    tnew_M = 2'd0;
    @(negedge clk);
    chk("lu3_en_D", {31'd0, en_D}, 32'd1);
    next_cyc();
    @(negedge clk);
    chk("lu_cnt", stall_cnt, 32'd2);

    // $zero and unused-operand filters
    next_cyc();
    clr_in();
    rt_D = 5'd0; tuse_rt_D = 2'd0; dst_E = 5'd0; tnew_E = 2'd2;
    @(negedge clk);
    chk("zero_en_D", {31'd0, en_D}, 32'd1);
    next_cyc();
    rt_D = 5'd5; tuse_rt_D = 2'd3; dst_E = 5'd5; tnew_E = 2'd2;
    @(negedge clk);
    chk("tuse3_en_D", {31'd0, en_D}, 32'd1);
    chk("filter_cnt", stall_cnt, 32'd2);

    // MDU: div then mult
    next_cyc();
    clr_in();
    run_md(1'b1, 11, 10, "div");
    @(negedge clk);
    chk("div_cnt", stall_cnt, 32'd12);
    next_cyc();
    run_md(1'b0, 6, 5, "mult");
    @(negedge clk);
    chk("mult_cnt", stall_cnt, 32'd17);

    // simultaneous data + MDU hazard counts once
    next_cyc();
    md_start_E = 1'b1; md_div_E = 1'b0; md_D = 1'b1;
    rs_D = 5'd8; tuse_rs_D = 2'd0; dst_E = 5'd8; tnew_E = 2'd1;
    @(negedge clk);
    chk("both_en_D", {31'd0, en_D}, 32'd0);
    next_cyc();
    clr_in();
    @(negedge clk);
    chk("both_cnt", stall_cnt, 32'd18);
    repeat (6) next_cyc();
    @(negedge clk);
    chk("both_idle", {31'd0, md_busy}, 32'd0);

    // reset mid-operation aborts the timer
    next_cyc();
    md_start_E = 1'b1; md_div_E = 1'b1;
    next_cyc();
    md_start_E = 1'b0; md_div_E = 1'b0; md_D = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    chk("pre_rst_en_D", {31'd0, en_D}, 32'd0);
    next_cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_md_busy", {31'd0, md_busy}, 32'd0);
    chk("async_en_D", {31'd0, en_D}, 32'd1);
    chk("async_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
      chk("post_rst_en_D", {31'd0, en_D}, 32'd1);
    end

    // saturation via backdoor preload
    next_cyc();
    clr_in();
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    mcnt = 64'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    rs_D = 5'd8; tuse_rs_D = 2'd0; dst_E = 5'd8; tnew_E = 2'd2;
    repeat (3) next_cyc();
    @(negedge clk);
    chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
    repeat (2) next_cyc();
    @(negedge clk);
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    next_cyc();
    clr_in();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
